seq_adder_nb: RTL and testbench

SEQ_ADDER_NB -- requirements
Module: seq_adder_nb

---
 rtl/seq_adder_nb.sv | 113 +++++++++++
 tb/tb_seq_adder_nb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_nb.sv
// seq_adder_nb: digit-serial adder/subtractor. It processes DIGIT bits per cycle,
// starting with the least significant slice, and carries between slices in a register.
// Optional feature macro: SEQ_ADDER_SUB_EN enables subtract mode (sub=1).
// Without the macro, sub is ignored and every operation is an addition.
module seq_adder_nb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int unsigned NSL = WIDTH / DIGIT;
  localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int unsigned SW  = DIGIT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             load_c;
  logic             last_c;
  logic [31:0]      sh_c;
  logic [SW-1:0]    slice_c;
  logic [WIDTH-1:0] b_ld_c;
  logic             c_ld_c;
  logic             msb_cin_c;

`ifdef SEQ_ADDER_SUB_EN
  // Subtract loads the inverted b and forces the carry-in to 1, so a + ~b + 1.
  assign b_ld_c = sub ? ~b : b;
  assign c_ld_c = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign b_ld_c     = b;
  assign c_ld_c     = cin;
  assign unused_sub = sub;
`endif

  assign load_c = start && (state == IDLE || state == DONE);
  assign last_c = (cnt_q == CW'(NSL - 1));
  assign sh_c   = 32'(cnt_q) * DIGIT;

  // Current slice sum: operand digits plus the carry registered from the previous slice.
  assign slice_c = SW'(DIGIT'(a_q >> sh_c)) + SW'(DIGIT'(b_q >> sh_c)) + SW'(carry_q);

  // Recover the carry into the MSB from its sum bit; this saves storing it separately.
  assign msb_cin_c = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_q[WIDTH-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, slice accumulation and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      ovf     <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state == DONE);
      if (state == DONE) begin
        sum <= {carry_q, acc_q};
        ovf <= msb_cin_c ^ carry_q;
      end
      if (load_c) begin
        a_q     <= a;
        b_q     <= b_ld_c;
        carry_q <= c_ld_c;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else if (state == RUN) begin
        // Shift the new slice in at the top, so slice 0 ends up at the LSB.
        acc_q   <= (acc_q >> DIGIT) | (WIDTH'(slice_c[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_q <= slice_c[DIGIT];
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_adder_nb.sv
// Testbench for seq_adder_nb: a table of vectors for the 4-bit/1-digit build, hand
// sequences for back-to-back, mid-run start and reset, and an 8-bit/4-digit instance.
module tb_seq_adder_nb;

  logic clk;
  logic rst;

  logic       start4, cin4, sub4, busy4, done4, ovf4;
  logic [3:0] a4, b4;
  logic [4:0] sum4;

  logic       start8, cin8, sub8, busy8, done8, ovf8;
  logic [7:0] a8, b8;
  logic [8:0] sum8;

  int n_tests = 0;
  int n_fail  = 0;

  seq_adder_nb #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .ovf(ovf4)
  );

  seq_adder_nb #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sub;
    logic [4:0] s;
    logic       o;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One 4-bit operation: busy for 4 cycles, then done with the result one cycle later.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc, input logic ts,
                     input logic [4:0] es, input logic eo, input string nm);
    logic [4:0] prev;
    logic       busy_ok;
    logic       held;
    @(negedge clk);
    prev = sum4;
    a4 = ta; b4 = tb; cin4 = tc; sub4 = ts; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    busy_ok = 1'b1;
    held    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (busy4 !== 1'b1 || done4 !== 1'b0) busy_ok = 1'b0;
      if (sum4 !== prev) held = 1'b0;
      @(negedge clk);
    end
    chk({nm, "_busy4"}, 64'(busy_ok), 64'd1);
    chk({nm, "_sumheld"}, 64'(held), 64'd1);
    chk({nm, "_gap"}, 64'({busy4, done4}), 64'd0);
    @(negedge clk);
    chk({nm, "_done"}, 64'({busy4, done4}), 64'b01);
    chk({nm, "_sum"}, 64'(sum4), 64'(es));
    chk({nm, "_ovf"}, 64'(ovf4), 64'(eo));
    @(negedge clk);
    chk({nm, "_pulse"}, 64'(done4), 64'd0);
  endtask

  // One 8-bit/4-digit operation: two slices, done 3 cycles after start.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [8:0] es,
                     input logic eo, input string nm);
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk({nm, "_busy0"}, 64'({busy8, done8}), 64'b10);
    @(negedge clk);
    chk({nm, "_busy1"}, 64'({busy8, done8}), 64'b10);
    @(negedge clk);
    chk({nm, "_gap"}, 64'({busy8, done8}), 64'b00);
    @(negedge clk);
    chk({nm, "_done"}, 64'(done8), 64'd1);
    chk({nm, "_sum"}, 64'(sum8), 64'(es));
    chk({nm, "_ovf"}, 64'(ovf8), 64'(eo));
  endtask

  vec_t vecs[9];

  initial begin
    logic ok;

    vecs[0] = '{4'b0110, 4'b1010, 1'b0, 1'b0, 5'b10000, 1'b0};
    vecs[1] = '{4'b0111, 4'b1110, 1'b1, 1'b0, 5'b10110, 1'b0};
    vecs[2] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 5'b11110, 1'b0};
    vecs[3] = '{4'b0111, 4'b0001, 1'b0, 1'b0, 5'b01000, 1'b1};
    vecs[4] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 5'b00001, 1'b0};
    vecs[5] = '{4'b1000, 4'b1000, 1'b0, 1'b0, 5'b10000, 1'b1};
    vecs[6] = '{4'b0101, 4'b0010, 1'b1, 1'b0, 5'b01000, 1'b1};
`ifdef SEQ_ADDER_SUB_EN
    vecs[7] = '{4'b0010, 4'b0100, 1'b0, 1'b1, 5'b01110, 1'b0};
    vecs[8] = '{4'b0101, 4'b0011, 1'b1, 1'b1, 5'b10010, 1'b0};
`else
    vecs[7] = '{4'b0010, 4'b0100, 1'b0, 1'b1, 5'b00110, 1'b0};
    vecs[8] = '{4'b0101, 4'b0011, 1'b1, 1'b1, 5'b01001, 1'b1};
`endif

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset4", 64'({busy4, done4, sum4, ovf4}), 64'd0);
    chk("reset8", 64'({busy8, done8, sum8, ovf8}), 64'd0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 9; i++)
      op4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].o,
          $sformatf("vec%0d", i));

    // start held high: done every 5 cycles; operands changed mid-run are taken at the next DONE.
    @(negedge clk);
    a4 = 4'b0011; b4 = 4'b0001; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done4 !== ((c == 5) || (c == 10))) ok = 1'b0;
      if (c == 0) begin a4 = 4'b0110; b4 = 4'b0001; end
      if (c == 5) chk("hold_sum1", 64'(sum4), 64'b00100);
      if (c == 10) chk("hold_sum2", 64'(sum4), 64'b00111);
    end
    chk("hold_done_pattern", 64'(ok), 64'd1);
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    // Start pulse mid-run with new operands is ignored.
    a4 = 4'b0110; b4 = 4'b0001; cin4 = 1'b0; start4 = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (c == 1) begin start4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; end
      if (done4 !== (c == 5)) ok = 1'b0;
      if (c == 5) begin
        chk("midstart_sum", 64'(sum4), 64'b00111);
        chk("midstart_ovf", 64'(ovf4), 64'd0);
      end
    end
    start4 = 1'b0;
    chk("midstart_done_pattern", 64'(ok), 64'd1);

    // Reset two cycles into RUN aborts; the next start right after release completes.
    @(negedge clk);
    a4 = 4'b1100; b4 = 4'b0011; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'({busy4, done4, sum4, ovf4}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a4 = 4'b0101; b4 = 4'b0001; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("rst_restart_busy", 64'(busy4), 64'd1);
    ok = 1'b1;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      if (done4 !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_done", 64'(ok), 64'd1);
    @(negedge clk);
    chk("rst_restart_done", 64'(done4), 64'd1);
    chk("rst_restart_sum", 64'(sum4), 64'b00110);

    // Multi-bit digits.
    op8(8'hFF, 8'h01, 9'h100, 1'b0, "w8_ff_01");
    op8(8'h7F, 8'h01, 9'h080, 1'b1, "w8_7f_01");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
